// File: rtl/cipher_tx_framer.sv
// Ciphertext serializer: buffers 24-bit words in a small FIFO and emits each as a
// frame of sync pattern, MSB-first data and an even-parity bit under tx_ready backpressure.
module cipher_tx_framer #(
  parameter int                N      = 24,
  parameter int                DEPTH  = 4,
  parameter int                SYNC_W = 8,
  parameter logic [SYNC_W-1:0] SYNC   = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init_done,
  input  logic [N-1:0]               data_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       tx_bit,
  output logic                       tx_valid,
  output logic                       tx_sof,
  input  logic                       tx_ready,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int BW  = $clog2((N > SYNC_W) ? N : SYNC_W);
  localparam int SIW = $clog2(SYNC_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_DATA   = 2'd2,
    ST_PARITY = 2'd3
  } state_e;

  function automatic logic even_parity(input logic [N-1:0] word);
    return ^word;
  endfunction

  logic [N-1:0]   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;

  state_e         state_q, state_d;
  logic [BW-1:0]  bitcnt_q, bitcnt_d;
  logic [N-1:0]   shift_q, shift_d;
  logic           parity_q, parity_d;

  logic           tx_valid_q, tx_valid_d;
  logic           tx_sof_q, tx_sof_d;
  logic           tx_bit_q, tx_bit_d;

  logic           push_s, pop_s, xfer_s, fifo_nonempty_s;
  logic [SIW-1:0] sync_idx_s;

  // in_ready looks only at the registered count, so a same-cycle pop never opens a full FIFO
  assign in_ready        = rst & init_done & (count_q < CW'(DEPTH));
  assign push_s          = in_valid & in_ready;
  assign xfer_s          = tx_valid_q & tx_ready;
  assign fifo_nonempty_s = (count_q != {CW{1'b0}});

  assign tx_bit     = tx_bit_q;
  assign tx_valid   = tx_valid_q;
  assign tx_sof     = tx_sof_q;
  assign fifo_count = count_q;

  // FIFO occupancy next-state
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointers; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {N{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= data_in;
        wr_ptr_q        <= wr_ptr_q + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1'b1);
      end
      count_q <= count_d;
    end
  end

  // Framing FSM: next state, bit counter, shifter and pop strobe
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    pop_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_nonempty_s) begin
          pop_s    = 1'b1;
          shift_d  = mem_q[rd_ptr_q];
          parity_d = even_parity(mem_q[rd_ptr_q]);
          bitcnt_d = {BW{1'b0}};
          state_d  = ST_SYNC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (xfer_s) begin
          if (bitcnt_q == BW'(SYNC_W - 1)) begin
            bitcnt_d = {BW{1'b0}};
            state_d  = ST_DATA;
          end else begin
            bitcnt_d = bitcnt_q + BW'(1'b1);
          end
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_DATA: begin
        if (xfer_s) begin
          shift_d = {shift_q[N-2:0], 1'b0};
          if (bitcnt_q == BW'(N - 1)) begin
            bitcnt_d = {BW{1'b0}};
            state_d  = ST_PARITY;
          end else begin
            bitcnt_d = bitcnt_q + BW'(1'b1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (xfer_s) begin
          // Next word goes straight into SYNC so frames leave back-to-back
          if (fifo_nonempty_s) begin
            pop_s    = 1'b1;
            shift_d  = mem_q[rd_ptr_q];
            parity_d = even_parity(mem_q[rd_ptr_q]);
            bitcnt_d = {BW{1'b0}};
            state_d  = ST_SYNC;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_PARITY;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        bitcnt_d = {BW{1'b0}};
      end
    endcase
  end

  assign sync_idx_s = SIW'(SYNC_W - 1) - bitcnt_d[SIW-1:0];

  // Serial outputs are computed from next state so they can be registered
  always_comb begin
    tx_valid_d = (state_d != ST_IDLE);
    tx_sof_d   = (state_d == ST_SYNC) && (bitcnt_d == {BW{1'b0}});
    case (state_d)
      ST_SYNC:   tx_bit_d = SYNC[sync_idx_s];
      ST_DATA:   tx_bit_d = shift_d[N-1];
      ST_PARITY: tx_bit_d = parity_d;
      default:   tx_bit_d = 1'b0;
    endcase
  end

  // FSM and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= {BW{1'b0}};
      shift_q    <= {N{1'b0}};
      parity_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_sof_q   <= 1'b0;
      tx_bit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_valid_q <= tx_valid_d;
      tx_sof_q   <= tx_sof_d;
      tx_bit_q   <= tx_bit_d;
    end
  end

endmodule

// File: tb/tb_cipher_tx_framer.sv
// Directed plus randomized bench for cipher_tx_framer; frames are checked against
// a word-level model that builds {sync, word, parity} for every accepted word.
module tb_cipher_tx_framer;

  logic        clk;
  logic        rst;
  logic        init_done;
  logic [23:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic        tx_bit;
  logic        tx_valid;
  logic        tx_sof;
  logic        tx_ready;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit rnd_ready = 1'b0;

  logic [23:0] exp_q[$];
  bit          cap_bits[$];
  bit          cap_sof[$];
  int          cap_cyc[$];

  cipher_tx_framer dut (
    .clk        (clk),
    .rst        (rst),
    .init_done  (init_done),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_bit     (tx_bit),
    .tx_valid   (tx_valid),
    .tx_sof     (tx_sof),
    .tx_ready   (tx_ready),
    .fifo_count (fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Bits seen at negedge with valid&&ready are consumed at the following posedge
  always @(negedge clk) begin
    if (rst && tx_valid && tx_ready) begin
      cap_bits.push_back(tx_bit);
      cap_sof.push_back(tx_sof);
      cap_cyc.push_back(cyc);
    end
  end

  function automatic logic [32:0] frame_of(input logic [23:0] w);
    int ones = 0;
    for (int i = 0; i < 24; i++) ones += int'(w[i]);
    return {8'hA5, w, ones[0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic push(input logic [23:0] w, input int budget);
    bit acc = 1'b0;
    int k = 0;
    data_in  = w;
    in_valid = 1'b1;
    while (!acc && k < budget) begin
      @(negedge clk);
      acc = in_ready;
      tick(1);
      k++;
    end
    in_valid = 1'b0;
    check("push_accept", 64'(acc), 64'd1);
    if (acc) exp_q.push_back(w);
  endtask

  task automatic wait_bits(input string tag, input int n, input int budget);
    int k = 0;
    while (cap_bits.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check({tag, "_timeout"}, 64'(cap_bits.size() >= n), 64'd1);
  endtask

  task automatic clear_capture();
    cap_bits.delete();
    cap_sof.delete();
    cap_cyc.delete();
  endtask

  task automatic check_frames(input string tag);
    logic [23:0] w;
    logic [32:0] bits, sofs;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      if (cap_bits.size() < 33) begin
        check({tag, "_len"}, 64'(cap_bits.size()), 64'd33);
        exp_q.delete();
        clear_capture();
        return;
      end
      bits = '0;
      sofs = '0;
      for (int i = 0; i < 33; i++) begin
        bits = {bits[31:0], cap_bits.pop_front()};
        sofs = {sofs[31:0], cap_sof.pop_front()};
      end
      check({tag, "_frame"}, 64'(bits), 64'(frame_of(w)));
      check({tag, "_sof"}, 64'(sofs), 64'h1_0000_0000);
    end
    check({tag, "_extra_bits"}, 64'(cap_bits.size()), 64'd0);
    clear_capture();
  endtask

  initial begin
    logic [23:0] w;
    logic        held;
    rst       = 1'b0;
    init_done = 1'b1;
    data_in   = 24'h0;
    in_valid  = 1'b0;
    tx_ready  = 1'b1;

    // Reset values
    #3;
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_sof", 64'(tx_sof), 64'd0);
    check("rst_tx_bit", 64'(tx_bit), 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    tick(2);
    rst = 1'b1;
    tick(1);

    // 1. Basic frame and first-bit latency
    push(24'h5AC30F, 20);
    check("t1_valid_after_push", 64'(tx_valid), 64'd0);
    tick(1);
    check("t1_valid_rise", 64'(tx_valid), 64'd1);
    check("t1_sof_rise", 64'(tx_sof), 64'd1);
    check("t1_first_bit", 64'(tx_bit), 64'd1);
    wait_bits("t1", 33, 100);
    check("t1_valid_fall", 64'(tx_valid), 64'd0);
    check("t1_literal_frame", 64'(frame_of(24'h5AC30F)), 64'h0_A55A_C30F << 1);
    check_frames("t1");

    // 2. Odd-weight word gives parity 1
    push(24'h000001, 20);
    wait_bits("t2", 33, 100);
    check("t2_parity_bit", 64'(cap_bits[32]), 64'd1);
    check("t2_data_lsb", 64'(cap_bits[31]), 64'd1);
    check_frames("t2");

    // 3. Fill under backpressure, then drain back-to-back
    tx_ready = 1'b0;
    tick(1);
    for (int i = 1; i <= 5; i++) push(24'(i), 5);
    check("t3_count_full", 64'(fifo_count), 64'd4);
    data_in  = 24'd6;
    in_valid = 1'b1;
    tick(2);
    check("t3_in_ready_full", 64'(in_ready), 64'd0);
    check("t3_count_hold", 64'(fifo_count), 64'd4);
    in_valid = 1'b0;
    tx_ready = 1'b1;
    wait_bits("t3", 165, 400);
    check("t3_no_gaps", 64'(cap_cyc[164] - cap_cyc[0]), 64'd164);
    check_frames("t3");
    tick(1);
    check("t3_drained", 64'(fifo_count), 64'd0);
    check("t3_idle", 64'(tx_valid), 64'd0);

    // 4. Stall at data bit 10
    w = 24'($urandom);
    push(w, 20);
    wait_bits("t4_pre", 18, 100);
    tx_ready = 1'b0;
    held = tx_bit;
    check("t4_bit10", 64'(tx_bit), 64'(w[13]));
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("t4_frozen_bit", 64'(tx_bit), 64'(held));
      check("t4_frozen_idx", 64'(cap_bits.size()), 64'd18);
    end
    tx_ready = 1'b1;
    wait_bits("t4", 33, 100);
    check_frames("t4");

    // 5. init_done gating
    init_done = 1'b0;
    data_in   = 24'($urandom);
    in_valid  = 1'b1;
    tick(3);
    check("t5_gated_ready", 64'(in_ready), 64'd0);
    check("t5_gated_count", 64'(fifo_count), 64'd0);
    check("t5_gated_idle", 64'(tx_valid), 64'd0);
    in_valid  = 1'b0;
    init_done = 1'b1;
    tx_ready  = 1'b0;
    for (int i = 0; i < 3; i++) push(24'($urandom), 5);
    check("t5_queued", 64'(fifo_count), 64'd2);
    init_done = 1'b0;
    data_in   = 24'($urandom);
    in_valid  = 1'b1;
    tick(2);
    check("t5_blocked_ready", 64'(in_ready), 64'd0);
    tx_ready = 1'b1;
    wait_bits("t5", 99, 300);
    in_valid = 1'b0;
    check_frames("t5");
    tick(2);
    check("t5_no_more", 64'(fifo_count), 64'd0);
    check("t5_idle", 64'(tx_valid), 64'd0);
    init_done = 1'b1;

    // 6. Asynchronous reset at sync bit 3
    for (int i = 0; i < 3; i++) push(24'($urandom), 5);
    wait_bits("t6_pre", 3, 50);
    check("t6_pre_count", 64'(fifo_count), 64'd2);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_valid", 64'(tx_valid), 64'd0);
    check("t6_async_count", 64'(fifo_count), 64'd0);
    check("t6_async_sof", 64'(tx_sof), 64'd0);
    check("t6_async_bit", 64'(tx_bit), 64'd0);
    check("t6_async_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    clear_capture();
    tick(2);
    rst = 1'b1;
    tick(1);
    push(24'hFFFFFF, 20);
    wait_bits("t6", 33, 100);
    check("t6_parity", 64'(cap_bits[32]), 64'd0);
    check_frames("t6");
    tick(2);
    check("t6_idle", 64'(tx_valid), 64'd0);

    // Randomized words, gaps and backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(24'($urandom), 2000);
      tick($urandom_range(0, 40));
    end
    wait_bits("rnd", 330, 3000);
    rnd_ready = 1'b0;
    tx_ready  = 1'b1;
    check_frames("rnd");
    tick(2);
    check("rnd_idle", 64'(tx_valid), 64'd0);
    check("rnd_empty", 64'(fifo_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cipher_tx_framer.md
Name: cipher_tx_framer

Overview:
Downstream stage of the encryptor. Accepts 24-bit ciphertext words through a valid/ready handshake and buffers them in a small FIFO. Each word is serialized MSB-first into a framed bitstream: sync pattern, data bits, then an even-parity bit. The bitstream feeds the channel modulator, which can apply backpressure. Word acceptance is gated by the keystream generator's init_done.

Parameters:
N, 24, ciphertext word width
DEPTH, 4, FIFO entries (power of 2, >=2)
SYNC_W, 8, sync pattern width
SYNC, 8'hA5, sync pattern, sent MSB-first

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
init_done  input  1  keystream ready; words accepted only while high
data_in  input  N  ciphertext word
in_valid  input  1  data_in valid
in_ready  output  1  framer can accept a word this cycle
tx_bit  output  1  current serial bit
tx_valid  output  1  tx_bit valid
tx_sof  output  1  high while tx_bit is the first sync bit of a frame
tx_ready  input  1  downstream consumes tx_bit when high with tx_valid
fifo_count  output  $clog2(DEPTH)+1  words currently queued, excluding the word being sent

Behaviour:
- Reset (rst=0, async): FIFO empty, fifo_count=0, state IDLE, bit counter 0, shift register 0. tx_valid=0, tx_sof=0, tx_bit=0, in_ready=0 immediately.
- in_ready = init_done && (fifo_count < DEPTH). It is computed from registered count only, so a pop in the same cycle does not open a full FIFO.
- Push: on a clock edge with in_valid && in_ready, data_in is written at the write pointer. Pointers wrap modulo DEPTH.
- A bit transfer occurs on an edge where tx_valid && tx_ready.
- FSM states: IDLE, SYNC, DATA, PARITY.
  - IDLE: tx_valid=0. If fifo_count>0 at an edge: pop the head into the shift register, latch parity = XOR of the word, bitcnt=0, go to SYNC. Result: a word pushed at edge k gives tx_valid=1 after edge k+1.
  - SYNC: tx_bit = SYNC[SYNC_W-1-bitcnt]. tx_sof = (bitcnt==0). Each transfer increments bitcnt. The transfer at bitcnt=SYNC_W-1 clears bitcnt and moves to DATA.
  - DATA: tx_bit = shift[N-1]. Each transfer shifts left by 1 and increments bitcnt. The transfer at bitcnt=N-1 moves to PARITY.
  - PARITY: tx_bit = latched even-parity bit, so the ones count over data plus parity is even. On transfer: if fifo_count>0, pop the next word and go directly to SYNC (no idle cycle); otherwise go to IDLE.
- Frame length is SYNC_W+N+1 = 33 bits. tx_valid stays high for the whole frame.
- tx_ready=0 holds state, bitcnt and tx_bit unchanged. There is no timeout.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- Push into an empty FIFO while IDLE: the word is stored and popped on the following edge. There is no bypass path.
- init_done falling mid-operation: blocks new pushes only. The frame in flight and all queued words are still transmitted.
- Reset mid-frame: the frame is abandoned, all queued words are discarded, and outputs go to their reset values asynchronously.
- fifo_count never exceeds DEPTH. An overflow is impossible by construction, since a push is not accepted while in_ready=0.

Test Plan:
1. Basic frame: rst release, init_done=1, tx_ready=1, push 24'h5AC30F at edge k. Required: tx_valid rises after edge k+1 with tx_sof=1. The 33 bits are 10100101, then 010110101100001100001111, then parity 0. tx_valid falls after the 33rd transfer.
2. Parity=1: push 24'h000001. Required: the data field ends in ...0001 and the parity bit is 1.
3. Fill/backpressure: tx_ready=0, in_valid=1 every cycle with words 1..6. Required: words 1-5 are accepted (word 1 sits in the shift register), fifo_count=4, in_ready=0, and word 6 is held. Raise tx_ready: the frames come out for words 1..5 in order, back-to-back, each with tx_sof, with no gap cycles.
4. Stall mid-data: drop tx_ready for 3 cycles at data bit 10. Required: tx_bit and the bit index are frozen. On resume, bit 10 is sent exactly once and the frame stays 33 bits.
5. init_done gating: with init_done=0 and in_valid=1, in_ready=0 and nothing is queued. Drop init_done while 2 words are queued. Required: both frames still transmit and no further pushes are accepted.
6. Async reset mid-frame: assert rst=0 at sync bit 3 with 2 words queued. Required: tx_valid=0 and fifo_count=0 without waiting for a clock edge. After release and a fresh push of 24'hFFFFFF, a clean frame is sent with parity 0.
